// File: rtl/process_pkg.sv
`default_nettype none
// +------------------------------------------------------------+
// | process_pkg: shared state encoding and default sizes for   |
// | the process_seq frame sequencer.              Rev 1.0      |
// +------------------------------------------------------------+
package process_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PTS   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int c_mat_beats = 3;
  localparam int c_ori_num   = 3;
  localparam int c_int_num   = 6;
  localparam int c_srt_lat   = 6;
  localparam int c_pipe_lat  = 46;

endpackage
`default_nettype wire

// File: rtl/seq_delay_line.sv
`default_nettype none
// +------------------------------------------------------------+
// | seq_delay_line: DEPTH-stage register chain, cleared by     |
// | areset.                                       Rev 1.0      |
// +------------------------------------------------------------+
module seq_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/process_seq.sv
`default_nettype none
// +------------------------------------------------------------+
// | process_seq: matrix/point frame sequencer with aligned     |
// | write strobes. Macro PROCESS_SEQ_BEAT_CNT_EN adds beat_cnt.|
// | Rev 1.0                                                    |
// +------------------------------------------------------------+
module process_seq
  import process_pkg::*;
#(
  parameter int MAT_BEATS = c_mat_beats,
  parameter int ORI_NUM   = c_ori_num,
  parameter int INT_NUM   = c_int_num,
  parameter int SRT_LAT   = c_srt_lat,
  parameter int PIPE_LAT  = c_pipe_lat
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        load_matrix,
  output logic [3:0]  mat_idx,
  output logic        vec_valid,
  output logic        ori_we,
  output logic        int_we,
  output logic [2:0]  pt_idx,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        busy,
  output logic        err_short
`ifdef PROCESS_SEQ_BEAT_CNT_EN
  ,
  output logic [15:0] beat_cnt
`endif
);

  localparam logic [3:0]  c_last_beat  = 4'(MAT_BEATS - 1);
  localparam logic [15:0] c_ori        = 16'(ORI_NUM);
  localparam logic [15:0] c_pts_total  = 16'(ORI_NUM + INT_NUM);
  localparam logic [15:0] c_drain_init = 16'(PIPE_LAT - 1);

  state_t      r_state, w_next_state;
  logic [3:0]  r_beat;
  logic [15:0] r_pc;
  logic [15:0] r_drain;
  logic        r_err;
  logic        w_hs, w_set_err, w_clr_err;
  logic        w_is_ori, w_is_int, w_is_out;
  logic [2:0]  w_idx;
  logic [4:0]  w_srt_in, w_srt_out;
  logic [1:0]  w_pipe_in, w_pipe_out;

  assign s_tready    = (r_state != DRAIN);
  assign w_hs        = s_tvalid & s_tready;
  assign load_matrix = w_hs & ((r_state == IDLE) | (r_state == LOAD));
  assign mat_idx     = load_matrix ? r_beat * 4'd4 : 4'd0;
  assign vec_valid   = w_hs & (r_state == PTS);
  assign busy        = (r_state != IDLE);
  assign err_short   = r_err;

  always_comb begin
    w_next_state = r_state;
    w_set_err    = 1'b0;
    w_clr_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_clr_err = 1'b1;
          if (s_tlast) w_set_err = 1'b1;
          else         w_next_state = (MAT_BEATS == 1) ? PTS : LOAD;
        end
      end
      LOAD: begin
        if (w_hs) begin
          if (r_beat == c_last_beat) begin
            w_next_state = PTS;
          end else if (s_tlast) begin
            w_set_err    = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      PTS: begin
        if (w_hs && s_tlast) begin
          w_next_state = DRAIN;
          if (r_pc < c_pts_total) w_set_err = 1'b1;
        end
      end
      DRAIN: begin
        if (r_drain == 16'd0) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_pc    <= '0;
      r_drain <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_set_err)      r_err <= 1'b1;
      else if (w_clr_err) r_err <= 1'b0;
      if (load_matrix) r_beat <= (w_next_state == LOAD) ? r_beat + 4'd1 : 4'd0;
      if (r_state == IDLE)                   r_pc <= '0;
      else if (vec_valid && r_pc != 16'hFFFF) r_pc <= r_pc + 16'd1;
      if (w_next_state == DRAIN && r_state != DRAIN)  r_drain <= c_drain_init;
      else if (r_state == DRAIN && r_drain != 16'd0)  r_drain <= r_drain - 16'd1;
    end
  end

  // Each accepted point is classified once here and its strobe rides the delay lines.
  assign w_is_ori = vec_valid && (r_pc < c_ori);
  assign w_is_int = vec_valid && !w_is_ori && (r_pc < c_pts_total);
  assign w_is_out = vec_valid && (r_pc >= c_pts_total);
  assign w_idx    = w_is_ori ? r_pc[2:0] : (w_is_int ? 3'(r_pc - c_ori) : 3'd0);

  assign w_srt_in  = {w_is_ori, w_is_int, w_idx};
  assign w_pipe_in = {w_is_out, w_is_out & s_tlast};

  seq_delay_line #(.DEPTH(SRT_LAT), .WIDTH(5)) u_srt_dly (
    .aclk   (aclk),
    .areset (areset),
    .i_data (w_srt_in),
    .o_data (w_srt_out)
  );

  seq_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(2)) u_pipe_dly (
    .aclk   (aclk),
    .areset (areset),
    .i_data (w_pipe_in),
    .o_data (w_pipe_out)
  );

  assign ori_we   = w_srt_out[4];
  assign int_we   = w_srt_out[3];
  assign pt_idx   = w_srt_out[2:0];
  assign m_tvalid = w_pipe_out[1];
  assign m_tlast  = w_pipe_out[0];

`ifdef PROCESS_SEQ_BEAT_CNT_EN
  logic [15:0] r_beat_cnt;

  always_ff @(posedge aclk) begin
    if (areset)                                      r_beat_cnt <= '0;
    else if (w_hs && r_state == IDLE)                r_beat_cnt <= '0;
    else if (m_tvalid && r_beat_cnt != 16'hFFFF)     r_beat_cnt <= r_beat_cnt + 16'd1;
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_process_seq.sv
`default_nettype none
// Self-checking bench for process_seq: per-cycle comparison against an
// event-scheduling reference model driven by directed and random frames.
module tb_process_seq;

  localparam int MAT_BEATS = 3;
  localparam int ORI_NUM   = 3;
  localparam int INT_NUM   = 6;
  localparam int SRT_LAT   = 6;
  localparam int PIPE_LAT  = 46;
  localparam int HORIZON   = 4096;

  logic        aclk = 1'b0;
  logic        areset, s_tvalid, s_tlast;
  logic        s_tready, load_matrix, vec_valid, ori_we, int_we;
  logic        m_tvalid, m_tlast, busy, err_short;
  logic [3:0]  mat_idx;
  logic [2:0]  pt_idx;
`ifdef PROCESS_SEQ_BEAT_CNT_EN
  logic [15:0] beat_cnt;
`endif

  always #5 aclk = ~aclk;

  process_seq #(
    .MAT_BEATS(MAT_BEATS), .ORI_NUM(ORI_NUM), .INT_NUM(INT_NUM),
    .SRT_LAT(SRT_LAT), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .load_matrix(load_matrix), .mat_idx(mat_idx),
    .vec_valid(vec_valid), .ori_we(ori_we), .int_we(int_we), .pt_idx(pt_idx),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .busy(busy), .err_short(err_short)
`ifdef PROCESS_SEQ_BEAT_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drained;
  logic obs_ready;

  // Expected delayed events, indexed by absolute cycle number.
  bit       exp_ori [HORIZON];
  bit       exp_int [HORIZON];
  bit [2:0] exp_idx [HORIZON];
  bit       exp_mv  [HORIZON];
  bit       exp_ml  [HORIZON];

  // Frame phase: 0 idle, 1 receiving matrix, 2 receiving points, 3 draining.
  int m_phase, m_mbeats, m_pts, m_drain, m_bcnt;
  bit m_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mbeats = 0; m_pts = 0; m_drain = 0; m_bcnt = 0; m_err = 1'b0;
    for (int i = cyc + 1; i < HORIZON; i++) begin
      exp_ori[i] = 1'b0; exp_int[i] = 1'b0; exp_idx[i] = 3'd0;
      exp_mv[i]  = 1'b0; exp_ml[i]  = 1'b0;
    end
  endtask

  task automatic schedule(input int n, input bit l);
    if (n < ORI_NUM) begin
      exp_ori[cyc + SRT_LAT] = 1'b1;
      exp_idx[cyc + SRT_LAT] = 3'(n);
    end else if (n < ORI_NUM + INT_NUM) begin
      exp_int[cyc + SRT_LAT] = 1'b1;
      exp_idx[cyc + SRT_LAT] = 3'(n - ORI_NUM);
    end else begin
      exp_mv[cyc + PIPE_LAT] = 1'b1;
      exp_ml[cyc + PIPE_LAT] = l;
    end
  endtask

  task automatic model_update(input bit hs, input bit l);
    if (exp_mv[cyc]) m_bcnt++;
    case (m_phase)
      0: if (hs) begin
           m_err  = l;
           m_bcnt = 0;
           if (!l) begin
             m_mbeats = 1;
             m_pts    = 0;
             m_phase  = (MAT_BEATS == 1) ? 2 : 1;
             if (MAT_BEATS == 1) m_mbeats = 0;
           end
         end
      1: if (hs) begin
           if (m_mbeats == MAT_BEATS - 1) begin
             m_phase = 2; m_pts = 0; m_mbeats = 0;
           end else if (l) begin
             m_err = 1'b1; m_phase = 0; m_mbeats = 0;
           end else begin
             m_mbeats++;
           end
         end
      2: if (hs) begin
           schedule(m_pts, l);
           if (l) begin
             if (m_pts < ORI_NUM + INT_NUM) m_err = 1'b1;
             m_phase = 3;
             m_drain = PIPE_LAT;
           end
           m_pts++;
         end
      default: begin
           m_drain--;
           if (m_drain == 0) m_phase = 0;
         end
    endcase
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input bit v, input bit l, input bit rst);
    bit rdy, hs, ld;
    s_tvalid = v; s_tlast = l; areset = rst;
    @(negedge aclk);
    rdy = (m_phase != 3);
    hs  = v && rdy;
    ld  = hs && (m_phase < 2);
    chk("s_tready", 16'(s_tready), 16'(rdy));
    chk("load_matrix", 16'(load_matrix), 16'(ld));
    chk("mat_idx", 16'(mat_idx), ld ? 16'(4 * m_mbeats) : 16'd0);
    chk("vec_valid", 16'(vec_valid), 16'(hs && m_phase == 2));
    chk("busy", 16'(busy), 16'(m_phase != 0));
    chk("err_short", 16'(err_short), 16'(m_err));
    chk("ori_we", 16'(ori_we), 16'(exp_ori[cyc]));
    chk("int_we", 16'(int_we), 16'(exp_int[cyc]));
    chk("pt_idx", 16'(pt_idx), 16'(exp_idx[cyc]));
    chk("m_tvalid", 16'(m_tvalid), 16'(exp_mv[cyc]));
    chk("m_tlast", 16'(m_tlast), 16'(exp_ml[cyc]));
`ifdef PROCESS_SEQ_BEAT_CNT_EN
    chk("beat_cnt", beat_cnt, 16'(m_bcnt));
`endif
    obs_ready = s_tready;
    if (rst) model_reset();
    else     model_update(hs, l);
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic send_matrix(input int gap_max);
    for (int i = 0; i < MAT_BEATS; i++) begin
      step(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, gap_max)) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // gap_mode: 0 continuous, 1 one idle cycle between points, 2 random 0..2.
  task automatic send_points(input int n, input int gap_mode);
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i == n - 1), 1'b0);
      if (i != n - 1) begin
        if (gap_mode == 1) step(1'b0, 1'b0, 1'b0);
        else if (gap_mode == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  // Runs until the model leaves DRAIN, counting cycles the DUT held s_tready low.
  task automatic wait_drain(output int n);
    int k;
    n = 0; k = 0;
    while (m_phase != 0 && k < 300) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (obs_ready === 1'b0) n++;
      k++;
    end
    if (k >= 300) begin
      checks++;
      failures++;
      $error("FAIL drain_timeout cyc=%0d observed=%0d expected=%0d", cyc, k, PIPE_LAT);
    end
  endtask

  initial begin
    areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
    @(posedge aclk);
    #1;
    model_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Nominal frame: 3 matrix beats, 12 continuous points.
    send_matrix(0);
    send_points(12, 0);
    wait_drain(drained);
    chk("nominal_drain_len", 16'(drained), 16'(PIPE_LAT));
    chk("nominal_idle", 16'(busy), 16'd0);
`ifdef PROCESS_SEQ_BEAT_CNT_EN
    chk("beat_cnt_nominal", beat_cnt, 16'd3);
`endif
    step(1'b0, 1'b0, 1'b0);

    // Points with single-cycle gaps.
    send_matrix(0);
    send_points(12, 1);
    wait_drain(drained);
    chk("gap_drain_len", 16'(drained), 16'(PIPE_LAT));

    // Short frame: tlast on matrix beat 1.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("short_matrix_err", 16'(err_short), 16'd1);
    chk("short_matrix_idle", 16'(busy), 16'd0);

    // Following frame clears err_short.
    send_matrix(0);
    chk("err_cleared", 16'(err_short), 16'd0);
    send_points(12, 0);
    wait_drain(drained);

    // Short points: tlast on point 5.
    send_matrix(0);
    send_points(5, 0);
    chk("short_pts_err", 16'(err_short), 16'd1);
    wait_drain(drained);
    chk("short_pts_drain_len", 16'(drained), 16'(PIPE_LAT));

    // Reset mid-PTS after point 7; pending events must never appear.
    send_matrix(0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("post_reset_ready", 16'(s_tready), 16'd1);
    chk("post_reset_busy", 16'(busy), 16'd0);
    repeat (PIPE_LAT + 4) step(1'b0, 1'b0, 1'b0);

    // Random frames: random gaps and point counts, random valid during drain.
    for (int f = 0; f < 5; f++) begin
      send_matrix(2);
      send_points($urandom_range(4, 14), 2);
      wait_drain(drained);
      chk("rand_drain_len", 16'(drained), 16'(PIPE_LAT));
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
